mem_unit: RTL and testbench

Memory-stage block that consumes the execute stage's result bundle (ALU/immediate result, store data, destination register, control strobes) and owns the EX/MEM pipeline register. It drives a single-request data-memory handshake with wait-state tolerance and a timeout watchdog. It stalls the upstream pipe while an access is outstanding and registers the write-back bundle for the WB stage.

---
 rtl/mem_unit_if.sv | 21 ++
 rtl/mem_unit.sv | 152 +++++++++++++++
 tb/tb_mem_unit.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_unit_if.sv
// Data-memory request bus between the memory stage and the data/stack RAMs.
// master: req/we/sel/addr/wdata out, ack/rdata in. slave: the reverse.
interface mem_unit_if;
   logic        dmem_req;
   logic        dmem_we;
   logic        dmem_sel;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic        dmem_ack;
   logic [31:0] dmem_rdata;

   modport master (
      output dmem_req, dmem_we, dmem_sel, dmem_addr, dmem_wdata,
      input  dmem_ack, dmem_rdata
   );

   modport slave (
      input  dmem_req, dmem_we, dmem_sel, dmem_addr, dmem_wdata,
      output dmem_ack, dmem_rdata
   );
endinterface

// File: rtl/mem_unit.sv
// Memory stage: owns the EX/MEM register, runs one data-memory access at a
// time with wait states and a timeout, stalls upstream, registers the WB bundle.
// Ports: clk, rst_n (async, active-low); *_in = EX bundle; stall_out;
// dmem = memory bus (master); wb_* = write-back bundle; mem_err = abort pulse.
module mem_unit #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        valid_in,
   input  logic        RegWrite_in,
   input  logic        MemWrite_in,
   input  logic        MemRead_in,
   input  logic        MemToReg_in,
   input  logic        MemSrc_in,
   input  logic        pop_in,
   input  logic [4:0]  DestReg_in,
   input  logic [31:0] EX_out_in,
   input  logic [31:0] MemWrite_data_in,
   output logic        stall_out,
   mem_unit_if.master  dmem,
   output logic        wb_valid,
   output logic        wb_RegWrite,
   output logic        wb_pop,
   output logic [4:0]  wb_DestReg,
   output logic [31:0] wb_data,
   output logic        mem_err
);

   localparam int CW = $clog2(TIMEOUT) + 1;
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   state_t        r_state;
   state_t        w_next;
   logic [CW-1:0] r_cnt;

   logic          r_valid;
   logic          r_regwrite;
   logic          r_memwrite;
   logic          r_memtoreg;
   logic          r_memsrc;
   logic          r_pop;
   logic [4:0]    r_dest;
   logic [31:0]   r_exout;
   logic [31:0]   r_wdata;

   logic          w_mem_in;
   logic          w_wait;
   logic          w_tmo;

   assign w_mem_in = valid_in & (MemRead_in | MemWrite_in);
   assign w_wait   = (r_state == S_WAIT);
   // An ack in the last allowed cycle completes normally.
   assign w_tmo    = w_wait & (r_cnt == LAST) & ~dmem.dmem_ack;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // A latched memory op is in WAIT from its capture edge until done,
   // so the state follows whatever the EX/MEM register picks up next.
   always_comb begin
      w_next = r_state;
      if (!stall_out) begin
         w_next = w_mem_in ? S_WAIT : S_IDLE;
      end
   end

   always_comb begin
      dmem.dmem_req = w_wait;
      stall_out     = w_wait & ~dmem.dmem_ack & ~w_tmo;
   end

   assign dmem.dmem_we    = r_memwrite;
   assign dmem.dmem_sel   = r_memsrc;
   assign dmem.dmem_addr  = r_exout;
   assign dmem.dmem_wdata = r_wdata;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (stall_out) begin
         r_cnt <= r_cnt + CW'(1);
      end else begin
         r_cnt <= '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid    <= 1'b0;
         r_regwrite <= 1'b0;
         r_memwrite <= 1'b0;
         r_memtoreg <= 1'b0;
         r_memsrc   <= 1'b0;
         r_pop      <= 1'b0;
         r_dest     <= '0;
         r_exout    <= '0;
         r_wdata    <= '0;
      end else if (!stall_out) begin
         r_valid    <= valid_in;
         r_regwrite <= valid_in & RegWrite_in;
         r_memwrite <= valid_in & MemWrite_in;
         r_memtoreg <= valid_in & MemToReg_in;
         r_memsrc   <= valid_in & MemSrc_in;
         r_pop      <= valid_in & pop_in;
         r_dest     <= DestReg_in;
         r_exout    <= EX_out_in;
         r_wdata    <= MemWrite_data_in;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_valid    <= 1'b0;
         wb_RegWrite <= 1'b0;
         wb_pop      <= 1'b0;
         wb_DestReg  <= '0;
         wb_data     <= '0;
      end else if (stall_out) begin
         wb_valid <= 1'b0;
      end else begin
         wb_valid   <= r_valid;
         wb_DestReg <= r_dest;
         if (w_tmo) begin
            wb_RegWrite <= 1'b0;
            wb_pop      <= 1'b0;
            wb_data     <= '0;
         end else begin
            wb_RegWrite <= r_regwrite;
            wb_pop      <= r_pop;
            wb_data     <= (w_wait & r_memtoreg) ? dmem.dmem_rdata
                                                 : r_exout;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_err <= 1'b0;
      end else begin
         mem_err <= w_tmo;
      end
   end

endmodule

// File: tb/tb_mem_unit.sv
// Randomized bench for mem_unit against a transaction-level reference.
// The bench plays the memory: it picks each access's ack delay up front.
module tb_mem_unit;

   localparam int TMO   = 16;
   localparam int NEVER = 99;

   typedef struct {
      logic        v, rw, mw, mr, m2r, ms, pop;
      logic [4:0]  dst;
      logic [31:0] ex, wd, rd;
      int          d;
   } ins_t;

   logic        clk;
   logic        rst_n;
   logic        valid_in, RegWrite_in, MemWrite_in, MemRead_in;
   logic        MemToReg_in, MemSrc_in, pop_in;
   logic [4:0]  DestReg_in;
   logic [31:0] EX_out_in, MemWrite_data_in;
   logic        stall_out;
   logic        wb_valid, wb_RegWrite, wb_pop;
   logic [4:0]  wb_DestReg;
   logic [31:0] wb_data;
   logic        mem_err;

   mem_unit_if dm();

   mem_unit #(.TIMEOUT(TMO)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .valid_in         (valid_in),
      .RegWrite_in      (RegWrite_in),
      .MemWrite_in      (MemWrite_in),
      .MemRead_in       (MemRead_in),
      .MemToReg_in      (MemToReg_in),
      .MemSrc_in        (MemSrc_in),
      .pop_in           (pop_in),
      .DestReg_in       (DestReg_in),
      .EX_out_in        (EX_out_in),
      .MemWrite_data_in (MemWrite_data_in),
      .stall_out        (stall_out),
      .dmem             (dm),
      .wb_valid         (wb_valid),
      .wb_RegWrite      (wb_RegWrite),
      .wb_pop           (wb_pop),
      .wb_DestReg       (wb_DestReg),
      .wb_data          (wb_data),
      .mem_err          (mem_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int fails  = 0;

   ins_t pres, lat;
   ins_t script[$];
   logic need_new;
   int   cnt;
   logic ewb, eerr, e_rw, e_pop;
   logic [4:0]  e_dst;
   logic [31:0] e_data;

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic is_mem(ins_t i);
      return i.v & (i.mr | i.mw);
   endfunction

   function automatic ins_t mk(logic v, logic rw, logic mr, logic mw,
                               logic m2r, logic [4:0] dst,
                               logic [31:0] ex, logic [31:0] wd,
                               logic [31:0] rd, int d);
      ins_t i;
      i.v = v; i.rw = rw; i.mr = mr; i.mw = mw; i.m2r = m2r;
      i.ms = 1'b0; i.pop = 1'b0; i.dst = dst;
      i.ex = ex; i.wd = wd; i.rd = rd; i.d = d;
      return i;
   endfunction

   function automatic ins_t rnd_ins();
      ins_t i;
      int   k;
      i.v   = ($urandom_range(0, 9) != 0);
      k     = $urandom_range(0, 3);
      i.mr  = (k == 1) || (k == 3);
      i.mw  = (k == 2) || (k == 3);
      i.rw  = 1'($urandom);
      i.m2r = 1'($urandom);
      i.ms  = 1'($urandom);
      i.pop = 1'($urandom);
      i.dst = 5'($urandom);
      i.ex  = $urandom;
      i.wd  = $urandom;
      i.rd  = $urandom;
      k     = $urandom_range(0, 9);
      if (k <= 3)      i.d = 0;
      else if (k <= 6) i.d = $urandom_range(1, 4);
      else if (k == 7) i.d = TMO - 1;
      else if (k == 8) i.d = NEVER;
      else             i.d = 2;
      return i;
   endfunction

   task automatic drive(ins_t i);
      valid_in         = i.v;
      RegWrite_in      = i.rw;
      MemWrite_in      = i.mw;
      MemRead_in       = i.mr;
      MemToReg_in      = i.m2r;
      MemSrc_in        = i.ms;
      pop_in           = i.pop;
      DestReg_in       = i.dst;
      EX_out_in        = i.ex;
      MemWrite_data_in = i.wd;
   endtask

   // One clock cycle, entered and left at posedge+1.
   task automatic run_cycle();
      logic ack, to, st;
      if (need_new) begin
         pres = (script.size() != 0) ? script.pop_front() : rnd_ins();
         drive(pres);
         need_new = 1'b0;
      end
      chk("wb_valid", wb_valid, ewb);
      if (ewb) begin
         chk("wb_DestReg", wb_DestReg, e_dst);
         chk("wb_RegWrite", wb_RegWrite, e_rw);
         chk("wb_pop", wb_pop, e_pop);
         chk("wb_data", wb_data, e_data);
      end
      chk("mem_err", mem_err, eerr);
      ack = 1'b0;
      to  = 1'b0;
      if (is_mem(lat)) begin
         chk("dmem_req", dm.dmem_req, 1);
         chk("dmem_addr", dm.dmem_addr, lat.ex);
         chk("dmem_wdata", dm.dmem_wdata, lat.wd);
         chk("dmem_we", dm.dmem_we, lat.mw);
         chk("dmem_sel", dm.dmem_sel, lat.ms);
         ack = (cnt == lat.d);
         to  = !ack && (cnt == TMO - 1);
         dm.dmem_ack   = ack;
         dm.dmem_rdata = ack ? lat.rd : $urandom;
         st     = !ack && !to;
         ewb    = !st;
         e_dst  = lat.dst;
         e_rw   = to ? 1'b0 : lat.rw;
         e_pop  = to ? 1'b0 : lat.pop;
         e_data = to ? 32'h0 : (lat.m2r ? lat.rd : lat.ex);
      end else begin
         chk("dmem_req_idle", dm.dmem_req, 0);
         dm.dmem_ack   = ($urandom_range(0, 3) == 0);
         dm.dmem_rdata = $urandom;
         st     = 1'b0;
         ewb    = lat.v;
         e_dst  = lat.dst;
         e_rw   = lat.rw;
         e_pop  = lat.pop;
         e_data = lat.ex;
      end
      eerr = to;
      #1;
      chk("stall_out", stall_out, st);
      @(posedge clk);
      #1;
      if (st) begin
         cnt++;
      end else begin
         lat      = pres;
         cnt      = 0;
         need_new = 1'b1;
      end
   endtask

   task automatic rst_start(ins_t op);
      rst_n = 1'b0;
      #1;
      chk("rst_req", dm.dmem_req, 0);
      chk("rst_stall", stall_out, 0);
      chk("rst_wb_valid", wb_valid, 0);
      chk("rst_wb_data", wb_data, 0);
      chk("rst_wb_dest", wb_DestReg, 0);
      chk("rst_wb_rw", wb_RegWrite, 0);
      chk("rst_wb_pop", wb_pop, 0);
      chk("rst_mem_err", mem_err, 0);
      chk("rst_addr", dm.dmem_addr, 0);
      chk("rst_wdata", dm.dmem_wdata, 0);
      chk("rst_we", dm.dmem_we, 0);
      chk("rst_sel", dm.dmem_sel, 0);
      dm.dmem_ack   = 1'b1;
      dm.dmem_rdata = 32'hBAD0BAD0;
      pres = op;
      drive(op);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      lat      = op;
      cnt      = 0;
      need_new = 1'b1;
      ewb      = 1'b0;
      eerr     = 1'b0;
   endtask

   initial begin
      int   n;
      ins_t nm;
      rst_n = 1'b1;
      lat   = mk(0, 0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0, 0);
      drive(lat);
      dm.dmem_ack   = 1'b0;
      dm.dmem_rdata = 32'h0;
      #2;
      nm = mk(1, 1, 0, 0, 0, 5'd5, 32'h1234, 32'h0, 32'h0, 0);
      rst_start(nm);
      script.push_back(mk(1, 1, 1, 0, 1, 5'd1, 32'h40, 32'h0,
                          32'hDEADBEEF, 0));
      script.push_back(mk(1, 1, 1, 0, 1, 5'd2, 32'h44, 32'h0,
                          32'h13579BDF, 0));
      script.push_back(mk(1, 1, 0, 1, 0, 5'd29, 32'h80, 32'hA5A5A5A5,
                          32'h0, 3));
      script.push_back(mk(1, 1, 1, 0, 1, 5'd3, 32'hC0, 32'h0,
                          32'h0, NEVER));
      script.push_back(mk(1, 1, 1, 0, 1, 5'd4, 32'hC4, 32'h0,
                          32'h600DF00D, TMO - 1));
      script.push_back(mk(1, 1, 0, 0, 0, 5'd6, 32'h55, 32'h0, 32'h0, 0));
      repeat (600) run_cycle();

      script.delete();
      script.push_back(mk(1, 1, 1, 0, 1, 5'd7, 32'h100, 32'h0,
                          32'h0, NEVER));
      n = 0;
      while (!(is_mem(lat) && lat.ex == 32'h100 && lat.d == NEVER &&
               cnt == 1) && n < 200) begin
         run_cycle();
         n++;
      end
      chk("reach_wait2", (n < 200), 1);
      rst_start(nm);
      repeat (40) run_cycle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
